// File: rtl/spi_responder_pkg.sv
// spi_responder_pkg: shared types and defaults for the SPI responder.
//   state_e             - frame state machine encoding (StIdle, StShift)
//   WIDTH_DEFAULT       - default frame length in bits
//   SYNC_STAGES_DEFAULT - default synchronizer depth
//   cnt_width()         - bit-counter width for a given frame length
package spi_responder_pkg;

    localparam int unsigned WIDTH_DEFAULT       = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // Counter must be able to represent WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for an asynchronous input with edge pulses.
//   clk, reset - system clock, synchronous active-high reset
//   d_i        - asynchronous input
//   q_o        - synchronized level
//   rise_o     - one-clk pulse on a synchronized 0->1 transition
//   fall_o     - one-clk pulse on a synchronized 1->0 transition
// SYNC_STAGES must be at least 2.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a CS already held low at reset release produces no
    // fall edge, so a frame interrupted by reset is ignored until CS cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target exchanging WIDTH-bit words with the CPU.
//   clk, reset           - system clock, synchronous active-high reset
//   spi_sck/cs_n/mosi    - asynchronous host pins, oversampled in clk domain
//   spi_miso, _oe        - data to host and its pad drive enable
//   rd, wr, tx_data      - CPU read-acknowledge, write strobe, word to send
//   rx_data, valid       - last received word and its unread flag
//   tx_pending, overrun  - tx buffer not yet sent; sticky lost-word flag
// Optional (macro SPI_RESPONDER_IRQ_EN): irq_mask input and irq output, a
// one-clk pulse per completed frame unless masked.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic             rd,
    input  logic             wr,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             valid,
    output logic             tx_pending,
`ifdef SPI_RESPONDER_IRQ_EN
    input  logic             irq_mask,
    output logic             irq,
`endif
    output logic             overrun
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sck_s, cs_s, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk    (clk),
        .reset  (reset),
        .d_i    (spi_sck),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .d_i    (spi_cs_n),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI needs no edge detection; same depth keeps it aligned with sck_rise.
    always_ff @(posedge clk) begin
        if (reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ---------------- FSM ----------------
    state_e state_q, state_d;
    logic   load_idle, bit_rise, bit_fall, abort;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StShift;
            StShift: if (cs_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_idle = 1'b0;
        bit_rise  = 1'b0;
        bit_fall  = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            StIdle:  load_idle = cs_fall;
            StShift: begin
                abort    = cs_rise;
                bit_rise = sck_rise & ~cs_rise;
                bit_fall = sck_fall & ~cs_rise;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    logic [WIDTH-1:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d, load_word;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic valid_q, valid_d, overrun_q, overrun_d, tx_pending_q, tx_pending_d;
    logic miso_q, miso_d, oe_q, oe_d, skip_fall_q, skip_fall_d;
    logic frame_done, load;

    assign frame_done = bit_rise && (bit_cnt_q == CntW'(WIDTH - 1));
    assign load       = load_idle | frame_done;
    assign load_word  = tx_pending_q ? tx_buf_q : '0;

    always_comb begin
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        rx_data_d    = rx_data_q;
        tx_buf_d     = tx_buf_q;
        bit_cnt_d    = bit_cnt_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        tx_pending_d = tx_pending_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        skip_fall_d  = skip_fall_q;

        if (bit_rise) begin
            shift_in_d = {shift_in_q[WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
        end
        if (bit_fall) begin
            // The fall right after a back-to-back reload already shows the new MSB.
            if (skip_fall_q) begin
                skip_fall_d = 1'b0;
            end else begin
                shift_out_d = shift_out_q << 1;
                miso_d      = shift_out_q[WIDTH-2];
            end
        end
        if (rd) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (frame_done) begin
            rx_data_d   = shift_in_d;
            valid_d     = 1'b1;
            if (valid_q && !rd) overrun_d = 1'b1;
            bit_cnt_d   = '0;
            skip_fall_d = 1'b1;
        end
        if (load) begin
            shift_out_d  = load_word;
            miso_d       = load_word[WIDTH-1];
            tx_pending_d = 1'b0;
        end
        if (load_idle) begin
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            skip_fall_d = 1'b0;
            oe_d        = 1'b1;
        end
        if (abort) begin
            oe_d        = 1'b0;
            skip_fall_d = 1'b0;
        end
        // A write racing a load: the load used the old buffer, the new word stays pending.
        if (wr) begin
            tx_buf_d     = tx_data;
            tx_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            rx_data_q    <= '0;
            tx_buf_q     <= '0;
            bit_cnt_q    <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            tx_pending_q <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            skip_fall_q  <= 1'b0;
        end else begin
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            rx_data_q    <= rx_data_d;
            tx_buf_q     <= tx_buf_d;
            bit_cnt_q    <= bit_cnt_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            tx_pending_q <= tx_pending_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            skip_fall_q  <= skip_fall_d;
        end
    end

`ifdef SPI_RESPONDER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= frame_done & ~irq_mask;
    end
    assign irq = irq_q;
`endif

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign rx_data     = rx_data_q;
    assign valid       = valid_q;
    assign overrun     = overrun_q;
    assign tx_pending  = tx_pending_q;

    // Synced levels are only used through their edge pulses.
    logic unused_levels;
    assign unused_levels = sck_s ^ cs_s;

endmodule

// File: tb/tb_spi_responder.sv
module tb_spi_responder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         spi_sck, spi_cs_n, spi_mosi;
    logic         spi_miso, spi_miso_oe;
    logic         rd, wr;
    logic [W-1:0] tx_data, rx_data;
    logic         valid, tx_pending, overrun;
`ifdef SPI_RESPONDER_IRQ_EN
    logic         irq_mask, irq;
    int           irq_cnt = 0;
    int           irq_exp = 0;
`endif

    spi_responder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rd          (rd),
        .wr          (wr),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .valid       (valid),
        .tx_pending  (tx_pending),
`ifdef SPI_RESPONDER_IRQ_EN
        .irq_mask    (irq_mask),
        .irq         (irq),
`endif
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the host and CPU should observe, word by word.
    logic [W-1:0] m_buf = '0, m_rx = '0, m_next_miso = '0;
    logic         m_pending = 1'b0, m_valid = 1'b0, m_overrun = 1'b0;

`ifdef SPI_RESPONDER_IRQ_EN
    always @(negedge clk) if (irq === 1'b1) irq_cnt++;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_load();
        m_next_miso = m_pending ? m_buf : '0;
        m_pending   = 1'b0;
    endtask

    task automatic model_complete(input logic [W-1:0] w);
        m_overrun = m_overrun | m_valid;
        m_valid   = 1'b1;
        m_rx      = w;
`ifdef SPI_RESPONDER_IRQ_EN
        if (!irq_mask) irq_exp++;
`endif
        model_load();
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".rx_data"}, rx_data, m_rx);
        check_eq({tag, ".valid"}, valid, m_valid);
        check_eq({tag, ".tx_pending"}, tx_pending, m_pending);
        check_eq({tag, ".overrun"}, overrun, m_overrun);
    endtask

    task automatic cpu_write(input logic [W-1:0] d);
        @(negedge clk);
        wr = 1'b1; tx_data = d;
        m_buf = d; m_pending = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic cpu_read();
        @(negedge clk);
        rd = 1'b1;
        m_valid = 1'b0; m_overrun = 1'b0;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic cs_assert(input string tag);
        @(negedge clk);
        spi_cs_n = 1'b0;
        model_load();
        repeat (8) @(negedge clk);
        check_eq({tag, ".oe_on"}, spi_miso_oe, 1'b1);
        check_eq({tag, ".txp_at_cs"}, tx_pending, m_pending);
    endtask

    task automatic cs_deassert(input string tag);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq({tag, ".oe_off"}, spi_miso_oe, 1'b0);
    endtask

    // Mode 0 at SCK = clk/8: MOSI set while SCK low, MISO sampled just before the rise.
    task automatic shift_word(input logic [W-1:0] mo, input int nbits, input string tag);
        logic [W-1:0] got;
        logic [W-1:0] exp;
        got = '0;
        exp = m_next_miso;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[W-1-i];
            repeat (4) @(negedge clk);
            got[W-1-i] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
        if (nbits == W) begin
            model_complete(mo);
            check_eq({tag, ".miso_word"}, got, exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  r;
        logic [W-1:0] mo;
        reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        rd = 1'b0; wr = 1'b0; tx_data = '0;
`ifdef SPI_RESPONDER_IRQ_EN
        irq_mask = 1'b0;
`endif
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_status("reset");
        check_eq("reset.miso", spi_miso, 1'b0);
        check_eq("reset.oe", spi_miso_oe, 1'b0);

        // Plain receive, nothing pending.
        cs_assert("tp1");
        shift_word(16'hA5C3, W, "tp1");
        cs_deassert("tp1");
        check_status("tp1");
        cpu_read();
        check_status("tp1_rd");

        // Pending word goes out on the next frame.
        cpu_write(16'h1234);
        check_eq("tp2.txp_set", tx_pending, 1'b1);
        cs_assert("tp2");
        shift_word(16'hFFFF, W, "tp2");
        cs_deassert("tp2");
        check_status("tp2");
        cpu_read();

        // Overrun on two unread frames.
        cs_assert("tp3a"); shift_word(16'h0001, W, "tp3a"); cs_deassert("tp3a");
        cs_assert("tp3b"); shift_word(16'h0002, W, "tp3b"); cs_deassert("tp3b");
        check_status("tp3");
        cpu_read();
        check_status("tp3_rd");

        // Back-to-back frames under one CS, second word written mid-frame.
        cpu_write(16'hBEEF);
        cs_assert("tp4");
        fork
            shift_word(16'h1357, W, "tp4a");
            begin
                repeat (40) @(negedge clk);
                cpu_write(16'hCAFE);
            end
        join
        shift_word(16'h2468, W, "tp4b");
        cs_deassert("tp4");
        check_status("tp4");
        cpu_read();

        // Aborted partial frame, then a full one.
        cs_assert("tp5a"); shift_word(16'hFFFF, 7, "tp5a"); cs_deassert("tp5a");
        check_status("tp5a");
        cs_assert("tp5b"); shift_word(16'h00FF, W, "tp5b"); cs_deassert("tp5b");
        check_status("tp5b");
        cpu_read();

        // Reset in the middle of a frame.
        cpu_write(16'h5A5A);
        cs_assert("tp6");
        shift_word(16'hF0F0, 9, "tp6");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_buf = '0; m_pending = 1'b0; m_valid = 1'b0; m_rx = '0; m_overrun = 1'b0;
        check_status("tp6_rst");
        check_eq("tp6_rst.miso", spi_miso, 1'b0);
        check_eq("tp6_rst.oe", spi_miso_oe, 1'b0);
        shift_word(16'hF0F0, 7, "tp6_tail");
        check_status("tp6_tail");
        cs_deassert("tp6");

        // Randomized traffic.
        for (int k = 0; k < 20; k++) begin
            r = $urandom;
`ifdef SPI_RESPONDER_IRQ_EN
            irq_mask = r[2];
`endif
            if (r[0]) cpu_write(W'($urandom));
            mo = W'($urandom);
            cs_assert("rnd");
            shift_word(mo, W, "rnd");
            if (r[3]) shift_word(W'($urandom), W, "rnd2");
            cs_deassert("rnd");
            check_status("rnd");
            if (r[1]) begin
                cpu_read();
                check_status("rnd_rd");
            end
        end

`ifdef SPI_RESPONDER_IRQ_EN
        repeat (4) @(negedge clk);
        check_eq("irq_count", irq_cnt, irq_exp);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI target (mode 0) that lets an external SPI host, such as a Raspberry Pi, exchange 16-bit words with the J1.
- It is the responder end of the SPI protocol that the J1 currently drives as initiator toward the flash.
- It sits on the J1 IO bus beside buart and has a buart-like CPU interface: a rd/wr strobe pair, a valid flag and a tx-pending flag.
- SPI pins are asynchronous and are oversampled in the clk domain.

Parameters:
- WIDTH, 16: frame length in bits, and the width of rx_data and tx_data.
- SYNC_STAGES, 2: number of flops in each input synchronizer (minimum 2).

Ports:
- clk  in  1: system clock (48 MHz).
- reset  in  1: synchronous, active-high reset.
- spi_sck  in  1: host SPI clock (async).
- spi_cs_n  in  1: host chip select, active low (async).
- spi_mosi  in  1: host data in (async).
- spi_miso  out  1: data to host.
- spi_miso_oe  out  1: drive enable for the MISO SB_IO; 1 while CS is asserted (synced).
- rd  in  1: CPU read strobe; acknowledges rx_data.
- wr  in  1: CPU write strobe; loads tx_data.
- tx_data  in  WIDTH: word to send in the next frame.
- rx_data  out  WIDTH: last complete received word.
- valid  out  1: rx_data is unread.
- tx_pending  out  1: tx buffer holds a word not yet sent.
- overrun  out  1: sticky; a frame completed while valid was already 1.

Behaviour:
- Reset values: rx_data=0, valid=0, tx_pending=0, overrun=0, spi_miso=0, spi_miso_oe=0, tx buffer=0, state IDLE, bit_cnt=0.
- Synchronizers: sck, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synced sck and cs_n only.
- Host SCK is limited to clk/8 (6 MHz); faster SCK is not supported.
- Mode 0: MOSI is sampled on the synced SCK rising edge; MISO updates on the synced SCK falling edge; both MSB first.
- State machine, IDLE:
  - Synced cs_n falling: shift_out <= tx buffer if tx_pending, else 0; tx_pending <= 0; spi_miso <= MSB of the loaded word; bit_cnt <= 0; go to SHIFT.
- State machine, SHIFT:
  - SCK rise: shift_in <= {shift_in[WIDTH-2:0], mosi}; bit_cnt++.
  - SCK fall: shift_out <<= 1; spi_miso <= new MSB.
- Frame complete: the rise that brings bit_cnt to WIDTH.
  - rx_data <= received word; valid <= 1; overrun <= 1 if valid was already 1 and rd is not asserted that cycle.
  - bit_cnt wraps to 0 and shift_out reloads from the tx buffer, using the IDLE rules. This is the back-to-back-frame rule while CS stays low.
  - The following SCK fall presents the new MSB and does not shift.
- CS rise in any state:
  - Return to IDLE and discard the partial rx word; valid and rx_data are unchanged.
  - A tx word already loaded into shift_out is lost. This is intended: software must resend it.
  - spi_miso_oe <= 0.
- rd:
  - Clears valid and overrun.
  - rd in the same cycle as frame completion: the new word wins, so valid=1, and overrun is not set.
- wr:
  - Tx buffer <= tx_data; tx_pending <= 1.
  - wr in the same cycle as a tx-buffer load: shift_out takes the old buffer contents (0 if nothing was pending), and tx_pending stays 1 with the new word.
- Reset mid-frame: all state returns to reset values immediately. The rest of the host's frame is ignored until CS deasserts and reasserts.
- spi_miso_oe follows synced ~cs_n with the same latency as state entry.

Optional Feature:
- SPI_RESPONDER_IRQ_EN defined:
  - Adds output irq (1 bit): a one-clk pulse on each frame completion, for J1 interrupt_request.
  - Also adds input irq_mask (1 bit): when 1, irq is suppressed.
- Undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package spi_responder_pkg holds:
  - the state enum (IDLE, SHIFT);
  - WIDTH_DEFAULT=16 and SYNC_STAGES_DEFAULT=2;
  - the bit-counter width function clog2(WIDTH+1).
- One sub-module, spi_sync: parameterised SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for sck and cs_n. mosi uses the synchronizer only.

Test Plan:
- Host sends 0xA5C3 at SCK=clk/8 with no tx pending -> rx_data=0xA5C3, valid=1; host reads MISO 0x0000; overrun=0.
- CPU wr 0x1234, then host frame with MOSI 0xFFFF -> host reads 0x1234; tx_pending falls at CS assert; rx_data=0xFFFF.
- Two frames without rd (0x0001, then 0x0002) -> rx_data=0x0002, overrun=1; a subsequent rd clears valid and overrun.
- CS held low for 32 bits; CPU writes 0xBEEF and 0xCAFE (the second written during frame 1) -> host sees 0xBEEF then 0xCAFE; valid set twice.
- CS deasserted after 7 bits, then a full frame 0x00FF -> the partial frame is discarded, rx_data=0x00FF, and the second frame's MISO is 0 if nothing was pending.
- Reset asserted at bit 9 -> all outputs return to reset values the next cycle; no valid until a new CS assertion. With SPI_RESPONDER_IRQ_EN, irq pulses exactly once per completed frame and never while irq_mask=1.
